// File: rtl/ifft_serial_if.sv
// Stream bundle for the serial IFFT: frequency-domain samples in, time-domain
// samples out, plus the busy flag. The block itself uses the slave view.
interface ifft_serial_if #(
  parameter int DW    = 16,
  parameter int LOG2N = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    in_re;
  logic signed [DW-1:0]    in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    out_re;
  logic signed [DW-1:0]    out_im;
  logic        [LOG2N-1:0] out_index;
  logic                    out_last;
  logic                    busy;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last, busy
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last, busy
  );
endinterface

// File: rtl/ifft_serial.sv
// Serial in-place radix-2 DIT inverse FFT. Samples are loaded in natural order
// into bit-reversed addresses, one butterfly runs per clock, and the result is
// streamed out in natural order. All state changes on the falling clock edge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | accepting N input samples, in_ready high
// COMPUTE | one butterfly per cycle, (N/2)*LOG2N cycles, busy high
// UNLOAD  | first cycle fetches x[0], then one sample per handshake
module ifft_serial #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int DW    = 16,
  parameter int TW    = 10
) (
  input  logic         clk,
  input  logic         rst,
  ifft_serial_if.slave bus
);

  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int BW = LOG2N - 1;
  localparam int PW = DW + TW;

  localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
  localparam logic [BW-1:0]    BF_LAST    = BW'(N / 2 - 1);
  localparam logic signed [PW-1:0] RND    = PW'(128);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t               state;
  logic [LOG2N-1:0]     cnt;
  logic [LOG2N-1:0]     cnt_nx;
  logic [SW-1:0]        stage;
  logic [BW-1:0]        bf;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic signed [DW-1:0] out_re_r;
  logic signed [DW-1:0] out_im_r;
  logic [LOG2N-1:0]     out_index_r;
  logic                 out_last_r;
  logic                 busy_r;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  logic [LOG2N-1:0]     bf_x;
  logic [LOG2N-1:0]     half_m;
  logic [LOG2N-1:0]     j_idx;
  logic [LOG2N-1:0]     idx_a;
  logic [LOG2N-1:0]     idx_b;
  logic [LOG2N-1:0]     tw_k;
  logic [4:0]           k64;
  logic signed [TW-1:0] tw_c;
  logic signed [TW-1:0] tw_s;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] br_x, bi_x, c_x, s_x;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [DW:0]   t_re, t_im;
  logic signed [DW:0]   ar_x, ai_x;
  logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;
  logic                 load_wr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Quarter-wave of round(256*cos(2*pi*i/64)) for i = 0..16.
  function automatic logic signed [TW-1:0] quarter(input logic [4:0] i);
    case (i)
      5'd0:    return TW'(256);
      5'd1:    return TW'(255);
      5'd2:    return TW'(251);
      5'd3:    return TW'(245);
      5'd4:    return TW'(237);
      5'd5:    return TW'(226);
      5'd6:    return TW'(213);
      5'd7:    return TW'(198);
      5'd8:    return TW'(181);
      5'd9:    return TW'(162);
      5'd10:   return TW'(142);
      5'd11:   return TW'(121);
      5'd12:   return TW'(98);
      5'd13:   return TW'(74);
      5'd14:   return TW'(50);
      5'd15:   return TW'(25);
      default: return TW'(0);
    endcase
  endfunction

  // Twiddles are tabulated on a 64-point circle; smaller N scales the index.
  function automatic logic signed [TW-1:0] cos_tw(input logic [4:0] k);
    if (k <= 5'd16) return quarter(k);
    return -quarter(5'(32 - int'(k)));
  endfunction

  function automatic logic signed [TW-1:0] sin_tw(input logic [4:0] k);
    if (k >= 5'd16) return quarter(k - 5'd16);
    return quarter(5'd16 - k);
  endfunction

  assign cnt_nx  = cnt + LOG2N'(1);
  assign load_wr = (state == LOAD) && bus.in_valid && in_ready_r;

  // Butterfly addressing, twiddle lookup and conjugate-twiddle arithmetic.
  always_comb begin
    bf_x   = {1'b0, bf};
    half_m = LOG2N'(1) << stage;
    j_idx  = bf_x & (half_m - LOG2N'(1));
    idx_a  = ((bf_x >> stage) << (stage + 1)) | j_idx;
    idx_b  = idx_a | half_m;
    tw_k   = j_idx << (LOG2N - 1 - stage);
    k64    = 5'(tw_k << (6 - LOG2N));
    tw_c   = cos_tw(k64);
    tw_s   = sin_tw(k64);

    a_re = mem_re[idx_a];
    a_im = mem_im[idx_a];
    b_re = mem_re[idx_b];
    b_im = mem_im[idx_b];

    br_x = PW'(b_re);
    bi_x = PW'(b_im);
    c_x  = PW'(tw_c);
    s_x  = PW'(tw_s);
    // b * (C + jS): rotation in the inverse direction
    p_re = br_x * c_x - bi_x * s_x;
    p_im = br_x * s_x + bi_x * c_x;
    t_re = (DW+1)'((p_re + RND) >>> 8);
    t_im = (DW+1)'((p_im + RND) >>> 8);

    ar_x   = (DW+1)'(a_re);
    ai_x   = (DW+1)'(a_im);
    sum_re = ar_x + t_re;
    sum_im = ai_x + t_im;
    dif_re = ar_x - t_re;
    dif_im = ai_x - t_im;
    // halving every stage folds the 1/N scale into the transform; no saturation
    na_re  = DW'(sum_re >>> 1);
    na_im  = DW'(sum_im >>> 1);
    nb_re  = DW'(dif_re >>> 1);
    nb_im  = DW'(dif_im >>> 1);
  end

  // Sample memory: bit-reversed load writes and in-place butterfly writes.
  always_ff @(negedge clk) begin
    if (load_wr) begin
      mem_re[bitrev(cnt)] <= bus.in_re;
      mem_im[bitrev(cnt)] <= bus.in_im;
    end else if (state == COMPUTE) begin
      mem_re[idx_a] <= na_re;
      mem_im[idx_a] <= na_im;
      mem_re[idx_b] <= nb_re;
      mem_im[idx_b] <= nb_im;
    end
  end

  // Sequencer with registered handshake and output signals.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      cnt         <= '0;
      stage       <= '0;
      bf          <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_re_r    <= '0;
      out_im_r    <= '0;
      out_index_r <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid && in_ready_r) begin
            if (cnt == CNT_LAST) begin
              state      <= COMPUTE;
              cnt        <= '0;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
              stage      <= '0;
              bf         <= '0;
            end else begin
              cnt <= cnt_nx;
            end
          end
        end
        COMPUTE: begin
          if (bf == BF_LAST) begin
            bf <= '0;
            if (stage == STAGE_LAST) begin
              state  <= UNLOAD;
              stage  <= '0;
              busy_r <= 1'b0;
            end else begin
              stage <= stage + SW'(1);
            end
          end else begin
            bf <= bf + BW'(1);
          end
        end
        UNLOAD: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_re_r    <= mem_re[cnt];
            out_im_r    <= mem_im[cnt];
            out_index_r <= cnt;
            out_last_r  <= (cnt == CNT_LAST);
          end else if (bus.out_ready) begin
            if (out_last_r) begin
              state       <= LOAD;
              cnt         <= '0;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_re_r    <= '0;
              out_im_r    <= '0;
              out_index_r <= '0;
              out_last_r  <= 1'b0;
            end else begin
              cnt         <= cnt_nx;
              out_re_r    <= mem_re[cnt_nx];
              out_im_r    <= mem_im[cnt_nx];
              out_index_r <= cnt_nx;
              out_last_r  <= (cnt_nx == CNT_LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_re    = out_re_r;
  assign bus.out_im    = out_im_r;
  assign bus.out_index = out_index_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ifft_serial.sv
// Bench for ifft_serial: known frames checked against a table of expected
// points, every frame checked against a floating-point IFFT, plus timing,
// backpressure and reset corner cases.
module tb_ifft_serial;
  localparam int  N     = 64;
  localparam int  LOG2N = 6;
  localparam int  DW    = 16;
  localparam int  TW    = 10;
  localparam real PI    = 3.14159265358979323846;

  typedef struct {
    string name;
    int    kind;
    int    n;
    int    er;
    int    ei;
    int    tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fr_re [N];
  int   fr_im [N];
  int   got_re [N];
  int   got_im [N];
  real  ref_re [N];
  real  ref_im [N];
  vec_t tbl [$];

  ifft_serial_if #(.DW(DW), .LOG2N(LOG2N)) bus ();

  ifft_serial #(.N(N), .LOG2N(LOG2N), .DW(DW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // 0 impulse at k=0, 1 single tone at k=1, 2 constant spectrum, 3 random
  task automatic build_frame(input int kind);
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
      case (kind)
        0: if (k == 0) fr_re[k] = 6400;
        1: if (k == 1) fr_re[k] = 6400;
        2: fr_re[k] = 640;
        default: begin
          fr_re[k] = int'($urandom_range(0, 4000)) - 2000;
          fr_im[k] = int'($urandom_range(0, 4000)) - 2000;
        end
      endcase
    end
  endtask

  // Direct-sum inverse DFT in double precision.
  task automatic compute_ref();
    real sr, si, ang;
    for (int n = 0; n < N; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < N; k++) begin
        ang = 2.0 * PI * real'(k * n) / real'(N);
        sr += real'(fr_re[k]) * $cos(ang) - real'(fr_im[k]) * $sin(ang);
        si += real'(fr_re[k]) * $sin(ang) + real'(fr_im[k]) * $cos(ang);
      end
      ref_re[n] = sr / real'(N);
      ref_im[n] = si / real'(N);
    end
  endtask

  task automatic send_frame();
    int w;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      w = 0;
      while (!bus.in_ready && w < 1000) begin
        @(posedge clk);
        w++;
      end
      if (w >= 1000) begin
        check("in_ready_timeout", 0, 1);
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_re    = 16'(fr_re[k]);
      bus.in_im    = 16'(fr_im[k]);
    end
  endtask

  task automatic receive(input bit bp);
    int got, cyc, stall, idx_bad, last_bad, hold_bad, ir_bad;
    int h_re, h_im;
    got = 0; cyc = 0; stall = 0; idx_bad = 0; last_bad = 0; hold_bad = 0; ir_bad = 0;
    h_re = 0; h_im = 0;
    while (got < N && cyc < 2000) begin
      if (!bus.out_valid) begin
        idx_bad++;
      end else begin
        if (bus.in_ready) ir_bad++;
        if (bp && int'(bus.out_index) == 10 && stall < 5) begin
          if (stall == 0) begin
            h_re = int'(bus.out_re);
            h_im = int'(bus.out_im);
          end else if (int'(bus.out_re) != h_re || int'(bus.out_im) != h_im ||
                       int'(bus.out_index) != 10 || bus.out_last) begin
            hold_bad++;
          end
          bus.out_ready = 1'b0;
          stall++;
        end else begin
          bus.out_ready = 1'b1;
          if (int'(bus.out_index) != got) idx_bad++;
          if (bus.out_last != (got == N - 1)) last_bad++;
          if (bp && got == 10 && (int'(bus.out_re) != h_re || int'(bus.out_im) != h_im)) hold_bad++;
          got_re[got] = int'(bus.out_re);
          got_im[got] = int'(bus.out_im);
          got++;
        end
      end
      @(posedge clk);
      cyc++;
    end
    bus.out_ready = 1'b1;
    check("frame_complete", got, N);
    check("index_sequence", idx_bad, 0);
    check("out_last_position", last_bad, 0);
    check("in_ready_low_in_unload", ir_bad, 0);
    if (bp) begin
      check("stall_cycles", stall, 5);
      check("hold_stable", hold_bad, 0);
    end
    check("in_ready_after_last", int'(bus.in_ready), 1);
    check("out_valid_after_last", int'(bus.out_valid), 0);
    check("out_zero_after_last", int'(bus.out_re) | int'(bus.out_im) |
          int'(bus.out_index) | int'(bus.out_last), 0);
  endtask

  task automatic apply_table(input int kind);
    foreach (tbl[i]) begin
      if (tbl[i].kind == kind) begin
        check_tol({tbl[i].name, "_re"}, got_re[tbl[i].n], tbl[i].er, tbl[i].tol);
        check_tol({tbl[i].name, "_im"}, got_im[tbl[i].n], tbl[i].ei, tbl[i].tol);
      end
    end
  endtask

  task automatic run_frame(input int kind, input bit bp, input bit pulse);
    int lat, busy_cnt, idle_bad;
    build_frame(kind);
    compute_ref();
    send_frame();
    @(posedge clk);
    bus.in_valid = 1'b0;
    lat = 0; busy_cnt = 0; idle_bad = 0;
    while (!bus.out_valid && lat < 400) begin
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) idle_bad++;
      if (bus.out_re != 0 || bus.out_im != 0 || bus.out_index != 0 || bus.out_last) idle_bad++;
      if (pulse) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_re    = 16'($urandom);
        bus.in_im    = 16'($urandom);
      end
      @(posedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("latency", lat, 193);
    check("busy_cycles", busy_cnt, 192);
    check("idle_outputs", idle_bad, 0);
    if (!bus.out_valid) return;
    receive(bp);
    for (int n = 0; n < N; n++) begin
      check_tol("ref_re", got_re[n], int'(ref_re[n]), 4);
      check_tol("ref_im", got_im[n], int'(ref_im[n]), 4);
    end
    apply_table(kind);
  endtask

  initial begin
    int cnt;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;

    for (int n = 0; n < N; n++) tbl.push_back('{"impulse", 0, n, 100, 0, 0});
    tbl.push_back('{"dir_x0",  1, 0,  100,    0, 2});
    tbl.push_back('{"dir_x16", 1, 16,   0,  100, 2});
    tbl.push_back('{"dir_x32", 1, 32, -100,   0, 2});
    tbl.push_back('{"dir_x48", 1, 48,   0, -100, 2});
    tbl.push_back('{"const_x0", 2, 0, 640, 0, 2});
    for (int n = 1; n < N; n++) tbl.push_back('{"const_rest", 2, n, 0, 0, 2});

    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_data", int'(bus.out_re) | int'(bus.out_im), 0);
    check("rst_out_index", int'(bus.out_index), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    repeat (3) @(posedge clk);
    rst = 1'b1;

    run_frame(0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(3, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b0);

    build_frame(0);
    send_frame();
    @(posedge clk);
    bus.in_valid = 1'b0;
    repeat (100) @(posedge clk);
    check("busy_before_rst", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (250) begin
      @(posedge clk);
      if (bus.out_valid) cnt++;
    end
    check("no_partial_output", cnt, 0);
    run_frame(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
